// File: rtl/serv_mem_responder.sv
// Arbitrates a single-port synchronous RAM among a host byte port, a data bus and an
// instruction bus. Each bus access is grant -> ack -> recover; host accesses are single-cycle.
module serv_mem_responder #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_ibus_cyc,
    input  logic [31:0]   i_ibus_adr,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    input  logic          i_dbus_cyc,
    input  logic [31:0]   i_dbus_adr,
    input  logic          i_dbus_we,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    output logic [31:0]   o_dbus_rdt,
    output logic          o_dbus_ack,
    input  logic          i_host_we,
    input  logic          i_host_re,
    input  logic [AW+1:0] i_host_adr,
    input  logic [7:0]    i_host_dat,
    output logic          o_host_rdy,
    output logic [7:0]    o_host_rdata,
    output logic          o_ram_en,
    output logic [AW-1:0] o_ram_a,
    output logic [3:0]    o_ram_we,
    output logic [31:0]   o_ram_di,
    input  logic [31:0]   i_ram_do,
    output logic          o_err,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {IDLE, RD, WR, RECOVER} state_t;

    state_t     state, state_nxt;
    logic       gnt_d, gnt_d_nxt;
    logic       oor, oor_nxt;
    logic       set_err;
    logic       host_pend, host_pend_nxt;
    logic [1:0] host_lane;
    logic [7:0] host_q;
    logic [7:0] host_byte;
    logic       d_oor, i_oor;

    // Bits [1:0] of bus addresses are don't-care: accesses are always word-wide.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{i_ibus_adr[1:0], i_dbus_adr[1:0]};

    assign d_oor = |i_dbus_adr[31:AW+2];
    assign i_oor = |i_ibus_adr[31:AW+2];

    assign dbg_state  = state;
    assign o_host_rdy = (state == IDLE) && rst_n;

    always_comb begin
        host_byte = i_ram_do[7:0];
        case (host_lane)
            2'd1:    host_byte = i_ram_do[15:8];
            2'd2:    host_byte = i_ram_do[23:16];
            2'd3:    host_byte = i_ram_do[31:24];
            default: host_byte = i_ram_do[7:0];
        endcase
    end

    // The read byte is forwarded straight from the RAM in the cycle it arrives, then held.
    assign o_host_rdata = host_pend ? host_byte : host_q;

    always_comb begin
        state_nxt     = state;
        gnt_d_nxt     = gnt_d;
        oor_nxt       = oor;
        set_err       = 1'b0;
        host_pend_nxt = 1'b0;
        o_ram_en      = 1'b0;
        o_ram_a       = '0;
        o_ram_we      = 4'b0000;
        o_ram_di      = 32'h0;
        o_ibus_ack    = 1'b0;
        o_ibus_rdt    = 32'h0;
        o_dbus_ack    = 1'b0;
        o_dbus_rdt    = 32'h0;
        case (state)
            IDLE: begin
                if (i_host_we) begin
                    o_ram_en = 1'b1;
                    o_ram_a  = i_host_adr[AW+1:2];
                    o_ram_we = 4'b0001 << i_host_adr[1:0];
                    o_ram_di = {4{i_host_dat}};
                end else if (i_host_re) begin
                    o_ram_en      = 1'b1;
                    o_ram_a       = i_host_adr[AW+1:2];
                    host_pend_nxt = 1'b1;
                end else if (i_dbus_cyc) begin
                    gnt_d_nxt = 1'b1;
                    oor_nxt   = d_oor;
                    set_err   = d_oor;
                    if (!d_oor) begin
                        o_ram_en = 1'b1;
                        o_ram_a  = i_dbus_adr[AW+1:2];
                        if (i_dbus_we) begin
                            o_ram_we = i_dbus_sel;
                            o_ram_di = i_dbus_dat;
                        end
                    end
                    state_nxt = i_dbus_we ? WR : RD;
                end else if (i_ibus_cyc) begin
                    gnt_d_nxt = 1'b0;
                    oor_nxt   = i_oor;
                    set_err   = i_oor;
                    if (!i_oor) begin
                        o_ram_en = 1'b1;
                        o_ram_a  = i_ibus_adr[AW+1:2];
                    end
                    state_nxt = RD;
                end
            end
            RD: begin
                // An out-of-range access still acks, but returns zero rather than stale RAM data.
                if (gnt_d) begin
                    o_dbus_ack = 1'b1;
                    o_dbus_rdt = oor ? 32'h0 : i_ram_do;
                end else begin
                    o_ibus_ack = 1'b1;
                    o_ibus_rdt = oor ? 32'h0 : i_ram_do;
                end
                state_nxt = RECOVER;
            end
            WR: begin
                o_dbus_ack = 1'b1;
                state_nxt  = RECOVER;
            end
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!rst_n) begin
            o_ram_en = 1'b0;
            o_ram_we = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_d     <= 1'b0;
            oor       <= 1'b0;
            o_err     <= 1'b0;
            host_pend <= 1'b0;
            host_lane <= 2'd0;
            host_q    <= 8'h00;
        end else begin
            state     <= state_nxt;
            gnt_d     <= gnt_d_nxt;
            oor       <= oor_nxt;
            o_err     <= o_err | set_err;
            host_pend <= host_pend_nxt;
            if (host_pend_nxt) host_lane <= i_host_adr[1:0];
            if (host_pend)     host_q    <= host_byte;
        end
    end

endmodule

// File: tb/tb_serv_mem_responder.sv
// Bench for serv_mem_responder: behavioural RAM, table of bus vectors, hand-written
// corner sequences, and an ack-driven scoreboard of expected read data.
module tb_serv_mem_responder;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_ibus_cyc;
    logic [31:0]   i_ibus_adr;
    logic [31:0]   o_ibus_rdt;
    logic          o_ibus_ack;
    logic          i_dbus_cyc;
    logic [31:0]   i_dbus_adr;
    logic          i_dbus_we;
    logic [31:0]   i_dbus_dat;
    logic [3:0]    i_dbus_sel;
    logic [31:0]   o_dbus_rdt;
    logic          o_dbus_ack;
    logic          i_host_we;
    logic          i_host_re;
    logic [AW+1:0] i_host_adr;
    logic [7:0]    i_host_dat;
    logic          o_host_rdy;
    logic [7:0]    o_host_rdata;
    logic          o_ram_en;
    logic [AW-1:0] o_ram_a;
    logic [3:0]    o_ram_we;
    logic [31:0]   o_ram_di;
    logic [31:0]   i_ram_do;
    logic          o_err;
    logic [1:0]    dbg_state;

    serv_mem_responder #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_ibus_cyc(i_ibus_cyc), .i_ibus_adr(i_ibus_adr),
        .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
        .i_dbus_cyc(i_dbus_cyc), .i_dbus_adr(i_dbus_adr), .i_dbus_we(i_dbus_we),
        .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
        .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
        .i_host_we(i_host_we), .i_host_re(i_host_re), .i_host_adr(i_host_adr),
        .i_host_dat(i_host_dat), .o_host_rdy(o_host_rdy), .o_host_rdata(o_host_rdata),
        .o_ram_en(o_ram_en), .o_ram_a(o_ram_a), .o_ram_we(o_ram_we),
        .o_ram_di(o_ram_di), .i_ram_do(i_ram_do),
        .o_err(o_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter / RAM model ----------------
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic [31:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        i_ram_do = 32'h0;
    end
    always @(posedge clk) begin
        if (o_ram_en) begin
            for (int l = 0; l < 4; l++)
                if (o_ram_we[l]) mem[o_ram_a][l*8 +: 8] <= o_ram_di[l*8 +: 8];
            i_ram_do <= mem[o_ram_a];
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];   // {check_rdt, is_dbus, rdt}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Scoreboard: every ack pops one expected entry.
    always @(negedge clk) begin
        logic [33:0] e;
        if (!o_ibus_ack) check("ibus_rdt_no_ack", o_ibus_rdt, 32'h0);
        if (!o_dbus_ack) check("dbus_rdt_no_ack", o_dbus_rdt, 32'h0);
        if (o_ibus_ack && o_dbus_ack) begin
            fail_now("both_acks");
        end else if (o_ibus_ack || o_dbus_ack) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_ack");
            end else begin
                e = exp_q.pop_front();
                check("ack_bus", {31'h0, o_dbus_ack}, {31'h0, e[32]});
                if (e[33]) check("ack_rdt", o_dbus_ack ? o_dbus_rdt : o_ibus_rdt, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_op(input bit is_d, input bit we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input bit chk, input logic [31:0] exp, input bit hold,
                          output int lat, output int ack_cyc);
        int start;
        @(posedge clk); #1;
        start = cyc_cnt;
        exp_q.push_back({chk, is_d, exp});
        if (is_d) begin
            i_dbus_cyc = 1'b1; i_dbus_adr = adr; i_dbus_we = we;
            i_dbus_dat = dat;  i_dbus_sel = sel;
        end else begin
            i_ibus_cyc = 1'b1; i_ibus_adr = adr;
        end
        ack_cyc = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (is_d ? o_dbus_ack : o_ibus_ack) begin
                ack_cyc = cyc_cnt;
                break;
            end
        end
        if (ack_cyc < 0) fail_now("bus_ack_timeout");
        lat = ack_cyc - start;
        if (!hold) begin
            @(posedge clk); #1;
            if (is_d) i_dbus_cyc = 1'b0; else i_ibus_cyc = 1'b0;
        end
    endtask

    task automatic wait_rdy();
        bit seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (o_host_rdy) begin seen = 1'b1; break; end
        end
        if (!seen) fail_now("host_rdy_timeout");
    endtask

    task automatic host_write(input logic [AW+1:0] adr, input logic [7:0] dat);
        @(posedge clk); #1;
        i_host_we = 1'b1; i_host_adr = adr; i_host_dat = dat;
        wait_rdy();
        @(posedge clk); #1;
        i_host_we = 1'b0;
    endtask

    task automatic host_read(input logic [AW+1:0] adr, input logic [7:0] exp);
        @(posedge clk); #1;
        i_host_re = 1'b1; i_host_adr = adr;
        wait_rdy();
        @(posedge clk); #1;
        i_host_re = 1'b0;
        @(negedge clk);
        check("host_rdata", {24'h0, o_host_rdata}, {24'h0, exp});
        @(negedge clk);
        check("host_rdata_hold", {24'h0, o_host_rdata}, {24'h0, exp});
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int lat, ac1, ac2, start, rel;
        bit seen;

        vecs[0] = '{0, 0, 32'h08, 32'h0,        4'h0, 1, 32'h00BB00DD};
        vecs[1] = '{1, 1, 32'h0C, 32'h12345678, 4'hF, 0, 32'h0};
        vecs[2] = '{1, 0, 32'h0F, 32'h0,        4'h0, 1, 32'h12345678};
        vecs[3] = '{1, 1, 32'h0E, 32'hFFFFFFFF, 4'h8, 0, 32'h0};
        vecs[4] = '{0, 0, 32'h0D, 32'h0,        4'h0, 1, 32'hFF345678};
        vecs[5] = '{1, 1, 32'h7C, 32'hDEADBEEF, 4'hF, 0, 32'h0};
        vecs[6] = '{1, 0, 32'h7F, 32'h0,        4'h0, 1, 32'hDEADBEEF};
        vecs[7] = '{1, 1, 32'h7C, 32'h00000000, 4'h6, 0, 32'h0};
        vecs[8] = '{0, 0, 32'h7C, 32'h0,        4'h0, 1, 32'hDE0000EF};
        vecs[9] = '{0, 0, 32'h03, 32'h0,        4'h0, 1, 32'h00000013};

        // Reset: a pending dbus request must not reach the RAM while reset is held.
        rst_n = 1'b0;
        i_ibus_cyc = 1'b0; i_ibus_adr = 32'h0;
        i_dbus_cyc = 1'b1; i_dbus_adr = 32'h0; i_dbus_we = 1'b1;
        i_dbus_dat = 32'hFFFFFFFF; i_dbus_sel = 4'hF;
        i_host_we = 1'b0; i_host_re = 1'b0; i_host_adr = '0; i_host_dat = 8'h0;
        repeat (2) @(negedge clk);
        check("rst_ram_en",   {31'h0, o_ram_en},   32'h0);
        check("rst_ram_we",   {28'h0, o_ram_we},   32'h0);
        check("rst_ibus_ack", {31'h0, o_ibus_ack}, 32'h0);
        check("rst_dbus_ack", {31'h0, o_dbus_ack}, 32'h0);
        check("rst_err",      {31'h0, o_err},      32'h0);
        check("rst_host_rdy", {31'h0, o_host_rdy}, 32'h0);
        check("rst_rdata",    {24'h0, o_host_rdata}, 32'h0);
        check("rst_state",    {30'h0, dbg_state},  32'h0);
        i_dbus_cyc = 1'b0; i_dbus_we = 1'b0;
        rst_n = 1'b1;
        #1;
        check("host_rdy_after_rst", {31'h0, o_host_rdy}, 32'h1);

        // Boot word via host bytes, then fetch it.
        host_write(7'h00, 8'h13);
        host_write(7'h01, 8'h00);
        host_write(7'h02, 8'h00);
        host_write(7'h03, 8'h00);
        bus_op(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h00000013, 0, lat, ac1);
        check("fetch_latency", lat, 1);

        // Byte-lane write then read back-to-back on the data bus.
        bus_op(1, 1, 32'h8, 32'hAABBCCDD, 4'b0101, 0, 32'h0, 1, lat, ac1);
        check("wr_latency", lat, 1);
        check("wr_state", {30'h0, dbg_state}, 32'h2);
        bus_op(1, 0, 32'h8, 32'h0, 4'h0, 1, 32'h00BB00DD, 0, lat, ac2);
        check("ack_spacing", ac2 - ac1, 3);
        @(negedge clk);
        check("recover_state", {30'h0, dbg_state}, 32'h3);

        for (int i = 0; i < 10; i++) begin
            bus_op(vecs[i].is_d, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                   vecs[i].chk, vecs[i].exp, 0, lat, ac1);
            check("vec_latency", lat, 1);
        end

        // Out-of-range read: no RAM access, ack with zero, sticky error.
        @(posedge clk); #1;
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        i_dbus_cyc = 1'b1; i_dbus_adr = 32'h0000_0100; i_dbus_we = 1'b0;
        @(negedge clk);
        check("oor_ram_en", {31'h0, o_ram_en}, 32'h0);
        check("oor_err_pre", {31'h0, o_err}, 32'h0);
        @(negedge clk);
        check("oor_ack", {31'h0, o_dbus_ack}, 32'h1);
        check("oor_err", {31'h0, o_err}, 32'h1);
        @(posedge clk); #1;
        i_dbus_cyc = 1'b0;

        // Out-of-range write must not touch RAM.
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 1'b1, 32'h0});
        i_dbus_cyc = 1'b1; i_dbus_adr = 32'h8000_0008; i_dbus_we = 1'b1;
        i_dbus_dat = 32'h55555555; i_dbus_sel = 4'hF;
        @(negedge clk);
        check("oor_wr_ram_we", {28'h0, o_ram_we}, 32'h0);
        @(negedge clk);
        check("oor_wr_ack", {31'h0, o_dbus_ack}, 32'h1);
        @(posedge clk); #1;
        i_dbus_cyc = 1'b0; i_dbus_we = 1'b0;
        bus_op(1, 0, 32'h8, 32'h0, 4'h0, 1, 32'h00BB00DD, 0, lat, ac1);
        check("err_sticky", {31'h0, o_err}, 32'h1);

        // Host write and dbus read in the same idle cycle: host first.
        @(posedge clk); #1;
        start = cyc_cnt;
        i_host_we = 1'b1; i_host_adr = 7'h14; i_host_dat = 8'h5A;
        exp_q.push_back({1'b1, 1'b1, 32'h0000005A});
        i_dbus_cyc = 1'b1; i_dbus_adr = 32'h14; i_dbus_we = 1'b0;
        @(negedge clk);
        check("prio_host_we", {28'h0, o_ram_we}, 32'h1);
        check("prio_no_dack", {31'h0, o_dbus_ack}, 32'h0);
        @(posedge clk); #1;
        i_host_we = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (o_dbus_ack) begin seen = 1'b1; break; end
        end
        if (!seen) fail_now("prio_ack_timeout");
        check("prio_ack_delay", cyc_cnt - start, 2);
        @(posedge clk); #1;
        i_dbus_cyc = 1'b0;

        // Reset during RD drops the ack; the still-pending fetch is served after release.
        @(posedge clk); #1;
        i_ibus_cyc = 1'b1; i_ibus_adr = 32'h0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack",  {31'h0, o_ibus_ack}, 32'h0);
        check("rst_mid_rdt",  o_ibus_rdt, 32'h0);
        check("rst_mid_err",  {31'h0, o_err}, 32'h0);
        check("rst_mid_rdy",  {31'h0, o_host_rdy}, 32'h0);
        repeat (2) @(negedge clk);
        exp_q.push_back({1'b1, 1'b0, 32'h00000013});
        rel = cyc_cnt;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (o_ibus_ack) begin seen = 1'b1; break; end
        end
        if (!seen) fail_now("post_rst_ack_timeout");
        check("post_rst_ack_delay", cyc_cnt - rel, 1);
        @(posedge clk); #1;
        i_ibus_cyc = 1'b0;

        // Host byte reads and the write-wins rule for simultaneous we/re.
        host_write(7'h08, 8'h44);
        host_write(7'h09, 8'h33);
        host_write(7'h0A, 8'h22);
        host_write(7'h0B, 8'h11);
        host_read(7'h0A, 8'h22);
        host_read(7'h0B, 8'h11);
        @(posedge clk); #1;
        i_host_we = 1'b1; i_host_re = 1'b1; i_host_adr = 7'h08; i_host_dat = 8'h99;
        @(negedge clk);
        check("we_re_ram_we", {28'h0, o_ram_we}, 32'h1);
        @(posedge clk); #1;
        i_host_we = 1'b0; i_host_re = 1'b0;
        @(negedge clk);
        check("we_re_rdata_held", {24'h0, o_host_rdata}, 32'h11);
        host_read(7'h08, 8'h99);
        bus_op(0, 0, 32'h8, 32'h0, 4'h0, 1, 32'h11223399, 0, lat, ac1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
